// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package wb_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int NUM_REGS       = 16;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_entry_t;

    // Addresses at or beyond the physical register count are dropped at drain time.
    function automatic logic addr_oob(input logic [DEFAULT_ADDR_W-1:0] a);
        return a >= DEFAULT_ADDR_W'(NUM_REGS);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous writeback FIFO with two push ports; push0 lands ahead of push1.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0,
    input  wb_entry_t        din0,
    input  logic             push1,
    input  wb_entry_t        din1,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_1;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p, input int unsigned n);
        int unsigned s;
        s = (32'(p) + n) % 32'(DEPTH);
        return PTR_W'(s);
    endfunction

    assign wr_ptr_1 = bump(wr_ptr, 1);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push0) mem[wr_ptr] <= din0;
            if (push1) mem[push0 ? wr_ptr_1 : wr_ptr] <= din1;
            wr_ptr <= bump(wr_ptr, 32'(push0) + 32'(push1));
            rd_ptr <= bump(rd_ptr, 32'(pop));
            count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Arbitrates LSU/ALU results into the writeback FIFO and drains it to the register file.
// Optional per-register pending scoreboard enabled by WB_SCOREBOARD_EN.
module regfile_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = wb_pkg::DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              rd_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_busy,
    output logic              oob_err
);
    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic             lsu_push;
    logic             alu_push;
    logic             pop;
    logic             issue;
    wb_entry_t        lsu_e;
    wb_entry_t        alu_e;
    wb_entry_t        head;

    // Handshake: a source transfers on a rising edge where valid and ready are both high;
    // ready never depends on this cycle's pop, and the LSU claims a free slot before the ALU.
    assign lsu_ready = 32'(count) < 32'(DEPTH);
    assign alu_ready = (32'(count) + 32'(lsu_valid)) < 32'(DEPTH);
    assign lsu_push  = lsu_valid && lsu_ready;
    assign alu_push  = alu_valid && alu_ready;
    assign pop       = (count != '0) && !rd_req;
    assign issue     = pop && !addr_oob(head.addr);

    assign lsu_e = '{addr: lsu_addr, data: lsu_data};
    assign alu_e = '{addr: alu_addr, data: alu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (lsu_push),
        .din0  (lsu_e),
        .push1 (alu_push),
        .din1  (alu_e),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we        <= 1'b0;
            rf_write_reg <= '0;
            rf_data      <= '0;
            oob_err      <= 1'b0;
        end else begin
            rf_we <= issue;
            if (issue) begin
                rf_write_reg <= head.addr;
                rf_data      <= head.data;
            end
            if ((lsu_push && addr_oob(lsu_addr)) || (alu_push && addr_oob(alu_addr)))
                oob_err <= 1'b1;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [2:0] pend_cnt [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) pend_cnt[i] <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_cnt[i] <= pend_cnt[i]
                             + 3'(lsu_push && (lsu_addr == ADDR_W'(i)))
                             + 3'(alu_push && (alu_addr == ADDR_W'(i)))
                             - 3'(issue && (head.addr == ADDR_W'(i)));
            end
        end
    end

    // The in-flight rf_we cycle still counts as pending for its register.
    assign q_busy = !addr_oob(q_addr)
                 && ((pend_cnt[q_addr[3:0]] != 3'd0) || (rf_we && (rf_write_reg == q_addr)));
`else
    logic unused_q_addr;
    assign unused_q_addr = ^q_addr;
    assign q_busy        = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed table, corner sequences and a queue-based model.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lsu_valid = 1'b0, alu_valid = 1'b0, rd_req = 1'b0;
    logic        lsu_ready, alu_ready, rf_we, q_busy, oob_err;
    logic [4:0]  lsu_addr = '0, alu_addr = '0, q_addr = '0, rf_write_reg;
    logic [31:0] lsu_data = '0, alu_data = '0, rf_data;

    regfile_wb_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_addr     (lsu_addr),
        .lsu_data     (lsu_data),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .rd_req       (rd_req),
        .rf_we        (rf_we),
        .rf_write_reg (rf_write_reg),
        .rf_data      (rf_data),
        .q_addr       (q_addr),
        .q_busy       (q_busy),
        .oob_err      (oob_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the pending writes in acceptance order plus the visible write port.
    typedef struct packed { logic [4:0] addr; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;
    logic        m_oob = 1'b0;
    logic        s_lr, s_ar;
    int          n_we = 0;

    function automatic logic model_busy(input logic [4:0] qa);
        logic b;
        b = m_we && (m_reg == qa);
        foreach (mq[i]) if (mq[i].addr == qa) b = 1'b1;
`ifdef WB_SCOREBOARD_EN
        return (qa < 5'd16) && b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic rq, input logic [4:0] qa);
        logic acc_l, acc_a;
        ent_t e;
        @(negedge clk);
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        rd_req = rq; q_addr = qa;
        #1;
        s_lr = lsu_ready; s_ar = alu_ready;
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, mq.size() < DEPTH});
        check("alu_ready", {31'd0, alu_ready}, {31'd0, (mq.size() + int'(lv)) < DEPTH});
        acc_l = lv && (mq.size() < DEPTH);
        acc_a = av && ((mq.size() + int'(lv)) < DEPTH);
        @(posedge clk);
        m_we = 1'b0;
        if (mq.size() > 0 && !rq) begin
            e = mq.pop_front();
            if (e.addr < 5'd16) begin
                m_we = 1'b1; m_reg = e.addr; m_data = e.data;
            end
        end
        if (acc_l) begin mq.push_back({la, ld}); if (la >= 5'd16) m_oob = 1'b1; end
        if (acc_a) begin mq.push_back({aa, ad}); if (aa >= 5'd16) m_oob = 1'b1; end
        #1;
        if (rf_we) n_we++;
        check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        if (m_we) begin
            check("rf_write_reg", {27'd0, rf_write_reg}, {27'd0, m_reg});
            check("rf_data", rf_data, m_data);
        end
        check("oob_err", {31'd0, oob_err}, {31'd0, m_oob});
        check("q_busy", {31'd0, q_busy}, {31'd0, model_busy(qa)});
    endtask

    task automatic idle(input logic rq, input logic [4:0] qa);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rq, qa);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lsu_valid = 1'b0; alu_valid = 1'b0; rd_req = 1'b0; q_addr = 5'd0;
        @(posedge clk);
        mq.delete(); m_we = 1'b0; m_reg = '0; m_data = '0; m_oob = 1'b0;
        #1;
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_rf_write_reg", {27'd0, rf_write_reg}, 32'd0);
        check("rst_rf_data", rf_data, 32'd0);
        check("rst_oob_err", {31'd0, oob_err}, 32'd0);
        check("rst_q_busy", {31'd0, q_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    endtask

    typedef struct {
        logic lv; logic [4:0] la; logic [31:0] ld;
        logic av; logic [4:0] aa; logic [31:0] ad;
        logic rq; logic ewe; logic [4:0] ereg; logic [31:0] edata;
    } vec_t;
    vec_t tbl[7];

    initial begin
        // Single write, then a same-cycle dual push to one register.
        tbl[0] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0};
        tbl[1] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b1, 5'd3, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0, 5'd0, 32'd0};
        tbl[3] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd1, 32'h22,      1'b0, 1'b0, 5'd0, 32'd0};
        tbl[4] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b1, 5'd1, 32'h11};
        tbl[5] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b1, 5'd1, 32'h22};
        tbl[6] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0, 5'd0, 32'd0};

        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].rq, 5'd0);
            check("tbl_we", {31'd0, rf_we}, {31'd0, tbl[i].ewe});
            if (tbl[i].ewe) begin
                check("tbl_reg", {27'd0, rf_write_reg}, {27'd0, tbl[i].ereg});
                check("tbl_data", rf_data, tbl[i].edata);
            end
        end

        // Read window: two queued entries held off for three cycles, then drained back-to-back.
        step(1'b1, 5'd2, 32'hA0A0, 1'b1, 5'd4, 32'hB0B0, 1'b1, 5'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 5'd0);
            check("rdwin_we_low", {31'd0, rf_we}, 32'd0);
        end
        idle(1'b0, 5'd0);
        check("rdwin_first", {27'd0, rf_write_reg, rf_we}, {27'd2, 1'b1});
        idle(1'b0, 5'd0);
        check("rdwin_second", {27'd0, rf_write_reg, rf_we}, {27'd4, 1'b1});
        idle(1'b0, 5'd0);

        // Full: three LSU accepts, then both valid at count 3, then both valid when full.
        for (int i = 0; i < 3; i++) step(1'b1, 5'(6 + i), 32'(100 + i), 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        step(1'b1, 5'd9, 32'd103, 1'b1, 5'd10, 32'd999, 1'b1, 5'd0);
        check("cnt3_lsu_ready", {31'd0, s_lr}, 32'd1);
        check("cnt3_alu_ready", {31'd0, s_ar}, 32'd0);
        step(1'b1, 5'd11, 32'd555, 1'b1, 5'd12, 32'd666, 1'b1, 5'd0);
        check("full_lsu_ready", {31'd0, s_lr}, 32'd0);
        check("full_alu_ready", {31'd0, s_ar}, 32'd0);
        n_we = 0;
        for (int i = 0; i < 6; i++) idle(1'b0, 5'd0);
        check("full_drain_writes", 32'(n_we), 32'd4);

        // Out-of-range address, then reset with entries pending.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'h1717, 1'b0, 5'd0);
        idle(1'b0, 5'd0);
        check("oob_no_we", {31'd0, rf_we}, 32'd0);
        check("oob_set", {31'd0, oob_err}, 32'd1);
        step(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b1, 5'd0);
        step(1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        do_reset();
        n_we = 0;
        for (int i = 0; i < 4; i++) idle(1'b0, 5'd0);
        check("post_reset_no_we", 32'(n_we), 32'd0);
        check("post_reset_oob", {31'd0, oob_err}, 32'd0);

        // Two pushes to register 5, watched through the scoreboard query.
        step(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 32'h56, 1'b0, 5'd5);
        idle(1'b0, 5'd5);
        check("sb_first_write", {31'd0, q_busy},
`ifdef WB_SCOREBOARD_EN
              32'd1);
`else
              32'd0);
`endif
        idle(1'b0, 5'd5);
        check("sb_second_write", {31'd0, q_busy},
`ifdef WB_SCOREBOARD_EN
              32'd1);
`else
              32'd0);
`endif
        idle(1'b0, 5'd5);
        check("sb_cleared", {31'd0, q_busy}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 19)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 19)), $urandom,
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 17)));
        end
        for (int i = 0; i < 8; i++) idle(1'b0, 5'($urandom_range(0, 15)));
        check("final_queue_empty", 32'(mq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL expose parameters, one per line: DEPTH, default 4, writeback FIFO entries; DATA_W, default 32, data width; ADDR_W, default 5, register address width.
REQ-002 SHALL have a single clock and a synchronous, active-high reset, with ports as below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 lsu_valid, lsu_ready  in/out  1  LSU result handshake.
REQ-006 lsu_addr, lsu_data  in  ADDR_W / DATA_W  LSU destination and result.
REQ-007 alu_valid, alu_ready  in/out  1  ALU result handshake.
REQ-008 alu_addr, alu_data  in  ADDR_W / DATA_W  ALU destination and result.
REQ-009 rd_req  in  1  decode needs a register-file read this cycle; writes are held off.
REQ-010 rf_we  out  1  register-file write enable (registered).
REQ-011 rf_write_reg  out  ADDR_W  register-file write address (registered).
REQ-012 rf_data  out  DATA_W  register-file write data (registered).
REQ-013 q_addr / q_busy  in / out  ADDR_W / 1  scoreboard query: register has a write pending.
REQ-014 oob_err  out  1  sticky flag: a write to address >= 16 was accepted.

Function
REQ-015 Transfer on a source SHALL occur on a rising edge with valid and ready both high; the pushed entry is {addr, data}.
REQ-016 lsu_ready SHALL be high iff count < DEPTH; alu_ready SHALL be high iff count + (lsu_valid ? 1 : 0) < DEPTH.
REQ-017 When both sources transfer in one cycle, the LSU entry SHALL be placed ahead of the ALU entry.
REQ-018 Drain: on an edge with FIFO not empty and rd_req = 0, the head SHALL be popped and loaded into rf_write_reg/rf_data with rf_we = 1 for the next cycle; otherwise rf_we = 0 next cycle and rf_write_reg/rf_data hold.
REQ-019 Latency: an entry pushed into an empty FIFO at edge k with rd_req low SHALL produce rf_we = 1 in the cycle after edge k+1; throughput is one write per cycle.
REQ-020 rd_req = 1 SHALL force rf_we = 0 in the following cycle, so register-file reads always see we low; there is no starvation limit.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged, and are legal when the FIFO is full (ready computed before the pop, so no accept occurs when full).
REQ-022 An entry with addr[ADDR_W-1:4] != 0 SHALL be accepted and popped, but SHALL NOT assert rf_we; it sets oob_err, which stays high until reset.
REQ-023 Write order to the same register SHALL equal acceptance order.

Reset
REQ-024 While reset is high at an edge, the FIFO SHALL be emptied, pending entries discarded without any write, and the scoreboard cleared.
REQ-025 Reset values: rf_we = 0, rf_write_reg = 0, rf_data = 0, oob_err = 0, q_busy = 0, lsu_ready = alu_ready = 1 from the first cycle after reset.

Configuration
REQ-026 Macro WB_SCOREBOARD_EN, defined: per-register pending counters (16 x 3 bits) SHALL be kept, incremented on push and decremented when rf_we issues for that address (simultaneous push and issue give no net change).
REQ-027 WB_SCOREBOARD_EN, defined: q_busy SHALL be high combinationally iff counter[q_addr] != 0 or (rf_we = 1 and rf_write_reg = q_addr); OOB addresses always report 0.
REQ-028 Macro WB_SCOREBOARD_EN, undefined: no counters SHALL be built and q_busy SHALL be tied to 0.

Structure
REQ-029 Shared package wb_pkg SHALL hold the DATA_W/ADDR_W defaults, NUM_REGS = 16, and typedef wb_entry_t {addr, data}.
REQ-030 Sub-module wb_fifo (synchronous FIFO of wb_entry_t, DEPTH, count output, dual push) SHALL implement the buffer; arbitration, drain and scoreboard live in regfile_wb_ctrl.

Verification
REQ-031 Single write: alu push {3, 0xDEADBEEF} at edge k, rd_req = 0 -> rf_we = 1, rf_write_reg = 3, rf_data = 0xDEADBEEF after edge k+1, for exactly one cycle.
REQ-032 Dual push: lsu {1, 0x11} and alu {1, 0x22} in the same cycle -> writes to reg 1 in order 0x11 then 0x22 on consecutive cycles.
REQ-033 Read window: 2 entries queued, rd_req held high 3 cycles -> rf_we = 0 throughout, then both writes drain back-to-back; no loss.
REQ-034 Full: 4 accepts without drain (rd_req = 1) -> lsu_ready = alu_ready = 0; 5th valid not accepted; with both valid and count = 3 -> only LSU accepted.
REQ-035 OOB and reset: push addr 17 -> oob_err = 1, no rf_we; reset asserted with 3 entries pending -> no rf_we afterwards, oob_err = 0.
REQ-036 Scoreboard (WB_SCOREBOARD_EN): two pushes to reg 5 -> q_busy(5) = 1 until the second write's rf_we cycle ends, then 0.
